// File: rtl/uvme_axis_st_pkt_arb.sv
// Round-robin packet arbiter: N_REQ AXI-Stream requesters onto one master port.
// Grants are held for a whole packet, and the master side has a single register stage.
module uvme_axis_st_pkt_arb #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 64,
    localparam int KEEP_W = DATA_W / 8,
    localparam int ID_W   = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      en,
    input  logic [N_REQ-1:0]          s_tvalid,
    input  logic [N_REQ-1:0]          s_tlast,
    output logic [N_REQ-1:0]          s_tready,
    input  logic [N_REQ*DATA_W-1:0]   s_tdata,
    input  logic [N_REQ*KEEP_W-1:0]   s_tkeep,
    output logic                      m_tvalid,
    output logic                      m_tlast,
    input  logic                      m_tready,
    output logic [DATA_W-1:0]         m_tdata,
    output logic [KEEP_W-1:0]         m_tkeep,
    output logic [ID_W-1:0]           m_tid,
    output logic [15:0]               pkt_cnt,
    output logic                      busy
);

    localparam int SUM_W = ID_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_t;

    state_t          state, state_next;
    logic [ID_W-1:0] grant, grant_next;
    logic [ID_W-1:0] rr_ptr, rr_ptr_next;

    logic              sel_tvalid_p0;
    logic              sel_tlast_p0;
    logic [DATA_W-1:0] sel_tdata_p0;
    logic [KEEP_W-1:0] sel_tkeep_p0;
    logic              out_ready;
    logic              s_hs_p0;

    // First requester at or above ptr, wrapping at N_REQ (not at 2**ID_W).
    function automatic logic [ID_W-1:0] pick_next(input logic [N_REQ-1:0] req,
                                                  input logic [ID_W-1:0]  ptr);
        logic [ID_W-1:0]  sel;
        logic [SUM_W-1:0] sum;
        logic             found;
        sel   = ptr;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, ptr} + SUM_W'(k);
            if (sum >= SUM_W'(N_REQ))
                sum = sum - SUM_W'(N_REQ);
            if (!found && req[sum[ID_W-1:0]]) begin
                sel   = sum[ID_W-1:0];
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] g);
        return (g == ID_W'(N_REQ - 1)) ? '0 : g + ID_W'(1);
    endfunction

    // Stage p0: select the granted requester's beat
    always_comb begin
        sel_tvalid_p0 = 1'b0;
        sel_tlast_p0  = 1'b0;
        sel_tdata_p0  = '0;
        sel_tkeep_p0  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant == ID_W'(i)) begin
                sel_tvalid_p0 = s_tvalid[i];
                sel_tlast_p0  = s_tlast[i];
                sel_tdata_p0  = s_tdata[i*DATA_W +: DATA_W];
                sel_tkeep_p0  = s_tkeep[i*KEEP_W +: KEEP_W];
            end
        end
    end

    assign out_ready = !m_tvalid || m_tready;
    assign s_hs_p0   = (state == PKT) && sel_tvalid_p0 && out_ready;
    assign busy      = (state == PKT);

    always_comb begin
        s_tready = '0;
        for (int i = 0; i < N_REQ; i++)
            s_tready[i] = (state == PKT) && (grant == ID_W'(i)) && out_ready;
    end

    always_comb begin
        state_next  = state;
        grant_next  = grant;
        rr_ptr_next = rr_ptr;
        case (state)
            IDLE: begin
                if (en && (|s_tvalid)) begin
                    grant_next = pick_next(s_tvalid, rr_ptr);
                    state_next = PKT;
                end
            end
            PKT: begin
                // en is ignored here: a granted packet always runs to tlast
                if (s_hs_p0 && sel_tlast_p0) begin
                    rr_ptr_next = next_idx(grant);
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_next;
            grant  <= grant_next;
            rr_ptr <= rr_ptr_next;
        end
    end

    // Stage p1: master-side output register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            m_tdata  <= '0;
            m_tkeep  <= '0;
            m_tid    <= '0;
        end else if (s_hs_p0) begin
            m_tvalid <= 1'b1;
            m_tlast  <= sel_tlast_p0;
            m_tdata  <= sel_tdata_p0;
            m_tkeep  <= sel_tkeep_p0;
            m_tid    <= grant;
        end else if (m_tvalid && m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            pkt_cnt <= '0;
        else if (m_tvalid && m_tready && m_tlast)
            pkt_cnt <= pkt_cnt + 16'd1;
    end

endmodule

// File: doc/uvme_axis_st_pkt_arb.md
UVME_AXIS_ST_PKT_ARB -- requirements
Module: uvme_axis_st_pkt_arb

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of AXI-Stream requester ports (2..16).
REQ-002 The block SHALL have parameter DATA_W, default 64, giving the tdata width in bits; tkeep width SHALL be DATA_W/8.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port en, input, 1 bit; when high, new grants are allowed.
REQ-006 The block SHALL have ports s_tvalid, s_tlast, s_tready (output), each N_REQ bits; bit i belongs to requester i.
REQ-007 The block SHALL have ports s_tdata (N_REQ*DATA_W bits) and s_tkeep (N_REQ*DATA_W/8 bits), inputs, with requester i in slice i.
REQ-008 The block SHALL have ports m_tvalid, m_tlast (outputs, 1 bit), m_tready (input, 1 bit), m_tdata (output, DATA_W bits) and m_tkeep (output, DATA_W/8 bits).
REQ-009 The block SHALL have port m_tid, output, clog2(N_REQ) bits, the index of the requester that sourced the current m_tdata beat.
REQ-010 The block SHALL have port pkt_cnt, output, 16 bits, the count of packets completed on the master side.
REQ-011 The block SHALL have port busy, output, 1 bit, high while the FSM is in state PKT.

Function
REQ-012 The FSM SHALL have exactly two states, IDLE and PKT.
REQ-013 In IDLE with en=1 and any s_tvalid high, the block SHALL latch grant = first requester with s_tvalid high, searching upward from rr_ptr with wrap modulo N_REQ, and SHALL move to PKT on the next edge.
REQ-014 In IDLE, s_tready SHALL be all-zero, giving a fixed 1-cycle arbitration bubble per packet.
REQ-015 In IDLE with en=0, the block SHALL stay in IDLE regardless of s_tvalid.
REQ-016 In PKT, s_tready[grant] SHALL equal (!m_tvalid || m_tready), and every other s_tready bit SHALL be 0.
REQ-017 The output stage SHALL be a single register: on an s-side handshake it loads m_tdata, m_tkeep, m_tlast and m_tid=grant and sets m_tvalid; on m_tvalid && m_tready with no new load, it clears m_tvalid.
REQ-018 The output stage SHALL sustain one beat per cycle when m_tready is held high; master-side latency SHALL be 1 cycle from the s-side handshake.
REQ-019 The output register SHALL hold m_tdata, m_tkeep, m_tlast and m_tid stable while m_tvalid=1 and m_tready=0.
REQ-020 When an s-side handshake with s_tlast=1 occurs, the block SHALL set rr_ptr=(grant+1) mod N_REQ and return to IDLE on the same edge.
REQ-021 Deasserting en during PKT SHALL NOT abort the packet; the grant SHALL hold until tlast.
REQ-022 Deasserting s_tvalid[grant] mid-packet SHALL hold the grant (no timeout) until tlast.
REQ-023 pkt_cnt SHALL increment by 1 on each master-side handshake with m_tlast=1, wrapping 0xFFFF to 0x0000.
REQ-024 A single-beat packet (tlast on the first beat) SHALL be handled as any other packet.
REQ-025 N_REQ values that are not a power of 2 SHALL wrap rr_ptr and the search at N_REQ-1, never selecting an index >= N_REQ.

Reset
REQ-026 While reset_n=0, the block SHALL hold: state=IDLE, rr_ptr=0, grant=0, m_tvalid=0, m_tlast=0, m_tdata=0, m_tkeep=0, m_tid=0, pkt_cnt=0, busy=0, s_tready=0.
REQ-027 Reset asserted mid-packet SHALL discard the buffered beat and the partial grant immediately, without waiting for a clock edge.

Verification
REQ-028 Scenario: all 4 requesters send 3-beat packets continuously, m_tready=1 -> m_tid sequence 0,0,0,1,1,1,2,2,2,3,3,3,0...; one idle cycle between packets; pkt_cnt=4 after the first round.
REQ-029 Scenario: only requester 2 is valid, 1-beat packets, 5 times -> five packets all with m_tid=2; rr_ptr=3 after each; pkt_cnt=5.
REQ-030 Scenario: m_tready=0 for 4 cycles mid-packet -> the m_* outputs stay stable, s_tready[grant]=0, and no beat is lost or duplicated after m_tready returns to 1.
REQ-031 Scenario: en drops after the first beat of an 8-beat packet from requester 1 -> all 8 beats forward; the FSM then stays in IDLE with busy=0 while requesters 0 and 3 are valid.
REQ-032 Scenario: reset_n is pulsed low during beat 2 of 4 -> m_tvalid=0, pkt_cnt=0 and busy=0 immediately; the next grant goes to the lowest valid index from 0.
REQ-033 Scenario: pkt_cnt is preloaded to 0xFFFF by forwarding 65535 packets, then one more packet is sent -> pkt_cnt=0x0000.
